score_controller: RTL
=====================

SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port startn, input, 1 bit: start key, active-low, synchronous to clock.
REQ-004 SHALL have port key_n, input, 4 bits: lane keys, active-low, one bit per lane 0..3.
REQ-005 SHALL have port tile_hit_zone, input, 4 bits: lane has a tile in the hit zone (level).
REQ-006 SHALL have port tick, input, 1 bit: one-cycle frame-advance strobe.
REQ-007 SHALL have port current_state, output, 6 bits: game state code for the score register and display.
REQ-008 SHALL have port increment, output, 1 bit: one-cycle score event pulse.
REQ-009 SHALL have port misses, output, 2 bits: miss count this game.
REQ-010 SHALL have port game_over, output, 1 bit: high while in OVER.

Function
REQ-011 SHALL encode states as IDLE=6'd0, ARM=6'd1, PLAY=6'd2, DRAIN=6'd3, OVER=6'd4; current_state is the registered state.
REQ-012 IDLE SHALL go to ARM when startn=0; ARM SHALL go to PLAY when startn=1 (key released).
REQ-013 PLAY SHALL go to DRAIN in the cycle after misses reaches 3; DRAIN SHALL go to OVER when no lane has pending hits.
REQ-014 OVER SHALL go to ARM when startn=0.
REQ-015 Entering ARM SHALL clear misses, all pending counters and all per-frame hit flags.
REQ-016 A press SHALL be a registered key_n bit going 1->0; the edge register SHALL reset to 4'b1111.
REQ-017 Presses SHALL be acted on only in PLAY; presses in other states are ignored.
REQ-018 In PLAY, a press on a lane with tile_hit_zone=1 SHALL increment that lane's 2-bit pending counter and set its frame hit flag.
REQ-019 Pending counters SHALL saturate at 3; further hits are dropped.
REQ-020 In PLAY, a press on a lane with tile_hit_zone=0 SHALL count one miss.
REQ-021 On tick in PLAY, each lane with tile_hit_zone=1 and frame hit flag=0 SHALL count one miss; all frame hit flags then clear.
REQ-022 A press and a tick in the same cycle on the same lane SHALL be judged press first, so that lane's tick sees its flag set and counts no miss.
REQ-023 Multiple misses in one cycle SHALL add together; misses SHALL saturate at 3.
REQ-024 A round-robin arbiter SHALL grant at most one lane with pending>0 per cycle, in PLAY or DRAIN; the granted lane's counter decrements.
REQ-025 Arbiter priority SHALL start at the lane after the last grant; after reset or ARM, priority starts at lane 0.
REQ-026 increment SHALL be registered, asserted the cycle after a grant, one cycle wide, at most one pulse per cycle.
REQ-027 A same-cycle grant and new hit on one lane SHALL net the counter (+1-1); saturation is checked on the net value.
REQ-028 game_over SHALL equal (state==OVER); in OVER and IDLE, increment SHALL be 0.

Reset
REQ-029 When resetn=0 at a rising edge, all registers SHALL reset: state=IDLE, increment=0, misses=0, game_over=0, counters and flags 0, arbiter pointer lane 0.
REQ-030 Reset SHALL override every other input in any state, including mid-DRAIN; pending hits are discarded.

Structure
REQ-031 A shared package SHALL hold the state encodings, NUM_LANES=4, MAX_MISSES=3 and PEND_MAX=3.
REQ-032 A sub-module lane_tracker SHALL be instantiated once per lane, containing edge detect, the frame hit flag and the pending counter.
REQ-033 The arbiter, miss accumulator and state machine SHALL sit in score_controller.

Verification
REQ-034 Reset, startn low 1 cycle then high -> states 0->1->2; misses=0; increment never pulses.
REQ-035 PLAY, tile_hit_zone=4'b0001, press lane 0 once -> exactly one increment pulse 2 cycles after the press edge; misses stays 0.
REQ-036 PLAY, presses on lanes 0,1,2,3 in the same cycle, all tiles present -> 4 increment pulses on 4 consecutive cycles, grant order 0,1,2,3.
REQ-037 PLAY, lane 2 pressed 5 times with its tile present and grants blocked by other pending lanes -> lane 2 produces at most 3 increments.
REQ-038 PLAY, tile_hit_zone=4'b1000 with no press, 3 ticks -> misses 1,2,3; DRAIN, then OVER; game_over=1; startn low -> ARM, misses=0.
REQ-039 Press plus tick in the same cycle on a tiled lane -> one increment and no miss; resetn low mid-DRAIN -> IDLE next cycle, no further increments.

Source files
------------

// File: rtl/score_controller_pkg.sv
// Shared encodings and sizing for the rhythm-game score controller.
package score_controller_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 2;
  localparam int MAX_MISSES = 3;
  localparam int PEND_MAX   = 3;

  typedef enum logic [5:0] {
    IDLE  = 6'd0,
    ARM   = 6'd1,
    PLAY  = 6'd2,
    DRAIN = 6'd3,
    OVER  = 6'd4
  } state_t;

endpackage

// File: rtl/score_controller_lane_tracker.sv
// One lane: key edge detect, per-frame hit flag and saturating pending-score counter.
module lane_tracker
  import score_controller_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       play,
  input  logic       key_n,
  input  logic       tile,
  input  logic       tick,
  input  logic       grant,
  output logic       miss_press,
  output logic       miss_tick,
  output logic [1:0] pending
);

  logic       key_q;
  logic       hit_flag;
  logic       press;
  logic       hit;
  logic [2:0] pend_net;

  assign press      = key_q & ~key_n;
  assign hit        = play & press & tile;
  assign miss_press = play & press & ~tile;
  // A press in the same cycle as the tick counts as this frame's hit.
  assign miss_tick  = play & tick & tile & ~(hit_flag | hit);
  assign pend_net   = {1'b0, pending} + {2'b0, hit} - {2'b0, grant};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_q    <= 1'b1;
      hit_flag <= 1'b0;
      pending  <= 2'd0;
    end else begin
      key_q <= key_n;
      if (clear) begin
        hit_flag <= 1'b0;
        pending  <= 2'd0;
      end else begin
        if (play && tick)
          hit_flag <= 1'b0;
        else if (hit)
          hit_flag <= 1'b1;
        pending <= (pend_net > 3'(PEND_MAX)) ? 2'(PEND_MAX) : pend_net[1:0];
      end
    end
  end

endmodule

// File: rtl/score_controller.sv
// Game state machine, miss accumulator and round-robin score arbiter over four lanes.
module score_controller
  import score_controller_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       startn,
  input  logic [3:0] key_n,
  input  logic [3:0] tile_hit_zone,
  input  logic       tick,
  output logic [5:0] current_state,
  output logic       increment,
  output logic [1:0] misses,
  output logic       game_over
);

  state_t                         state;
  logic                           play;
  logic                           active;
  logic                           clear;
  logic [NUM_LANES-1:0]           grant;
  logic [NUM_LANES-1:0]           miss_press;
  logic [NUM_LANES-1:0]           miss_tick;
  logic [NUM_LANES-1:0]           pend_nz;
  logic [NUM_LANES-1:0][1:0]      pending;
  logic [LANE_W-1:0]              ptr;
  logic [LANE_W-1:0]              idx;
  logic [LANE_W-1:0]              grant_idx;
  logic                           grant_valid;
  logic [3:0]                     miss_sum;
  logic [3:0]                     miss_total;

  assign play          = (state == PLAY);
  assign active        = (state == PLAY) || (state == DRAIN);
  assign clear         = ((state == IDLE) || (state == OVER)) && !startn;
  assign current_state = state;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_tracker u_lane (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (clear),
      .play       (play),
      .key_n      (key_n[i]),
      .tile       (tile_hit_zone[i]),
      .tick       (tick),
      .grant      (grant[i]),
      .miss_press (miss_press[i]),
      .miss_tick  (miss_tick[i]),
      .pending    (pending[i])
    );
    assign pend_nz[i] = |pending[i];
  end

  // Search starts at the lane after the previous grant.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + LANE_W'(k);
      if (active && !grant_valid && pend_nz[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_valid)
      grant[grant_idx] = 1'b1;
  end

  always_comb begin
    miss_sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      miss_sum = miss_sum + {3'b0, miss_press[i]} + {3'b0, miss_tick[i]};
    miss_total = {2'b0, misses} + miss_sum;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      misses    <= 2'd0;
      increment <= 1'b0;
      game_over <= 1'b0;
      ptr       <= '0;
    end else begin
      increment <= grant_valid;
      if (grant_valid)
        ptr <= grant_idx + LANE_W'(1);
      if (play)
        misses <= (miss_total > 4'(MAX_MISSES)) ? 2'(MAX_MISSES) : miss_total[1:0];
      case (state)
        IDLE: begin
          if (!startn) begin
            state  <= ARM;
            misses <= 2'd0;
            ptr    <= '0;
          end
        end
        ARM: begin
          if (startn)
            state <= PLAY;
        end
        PLAY: begin
          if (misses == 2'(MAX_MISSES))
            state <= DRAIN;
        end
        DRAIN: begin
          if (!(|pend_nz)) begin
            state     <= OVER;
            game_over <= 1'b1;
          end
        end
        OVER: begin
          if (!startn) begin
            state     <= ARM;
            misses    <= 2'd0;
            ptr       <= '0;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
